regfile_dump: RTL and testbench

- Debug read-out engine that walks the CPU register file through a spare read port (address out, combinational data in).
- Streams each register value, tagged with its index, over a valid/ready output channel to the debug/UART side.
- Sits beside the register file. Used while the pipeline is halted to snapshot r0..r31.

---
 rtl/regfile_dump_pkg.sv | 16 +
 rtl/regfile_dump.sv | 89 ++++++++
 tb/tb_regfile_dump.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// Register-file constants shared across the CPU.
// Also holds the state encoding of the debug dump FSM.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_st_e;

endpackage

// File: rtl/regfile_dump.sv
// Debug read-out engine that walks the register file through a
// spare read port and streams index-tagged words over valid/ready.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = NUM_REGS - 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rn,
  input  logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LP_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(LAST_REG);

  dump_st_e          r_state;
  dump_st_e          w_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_oidx;
  logic              w_go;
  logic              w_hs;
  logic              w_last;

  assign w_go   = (r_state == ST_IDLE) && start && !abort;
  assign w_hs   = (r_state == ST_SEND) && out_ready && !abort;
  assign w_last = (r_idx == LP_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_go) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_SEND;
      ST_SEND: if (w_hs) w_next = w_last ? ST_DONE : ST_LOAD;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // abort beats a same-cycle handshake
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                r_idx <= '0;
    else if (w_go)            r_idx <= LP_FIRST;
    else if (w_hs && !w_last) r_idx <= r_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_oidx  <= '0;
    end else if (abort) begin
      r_valid <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_valid <= 1'b1;
      r_data  <= q;
      r_oidx  <= r_idx;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign rn        = r_idx;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_oidx;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: register file plus a word-list
// reference model of what each dump must emit.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  rn;
  logic [31:0] q;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        busy;
  logic        done;

  logic        start2 = 1'b0;
  logic        ready2 = 1'b0;
  logic [4:0]  rn2;
  logic [31:0] q2;
  logic        ov2;
  logic [31:0] od2;
  logic [4:0]  oi2;
  logic        busy2;
  logic        done2;

  logic        rf_we = 1'b0;
  logic [4:0]  rf_wa = '0;
  logic [31:0] rf_wd = '0;
  logic [31:0] rf [32];
  logic [31:0] m_rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;

  assign q  = (rn == 5'd0)  ? 32'h0 : rf[rn];
  assign q2 = (rn2 == 5'd0) ? 32'h0 : rf[rn2];

  regfile_dump u_dut (
    .clk(clk), .clrn(clrn), .start(start), .abort(abort),
    .rn(rn), .q(q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
  );

  regfile_dump #(.FIRST_REG(29), .LAST_REG(29)) u_one (
    .clk(clk), .clrn(clrn), .start(start2), .abort(1'b0),
    .rn(rn2), .q(q2), .out_valid(ov2), .out_ready(ready2),
    .out_data(od2), .out_idx(oi2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    rf_we = 1'b1;
    rf_wa = 5'(a);
    rf_wd = d;
    cyc();
    rf_we = 1'b0;
    m_rf[a] = (a == 0) ? 32'h0 : d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rn"}, rn, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_od"}, out_data, 0);
    chk({tag, "_oi"}, out_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: ready high, 1: random ready, 2: stall word 3,
  // 3: abort at word 10, 4: start at word 7, 5: reset at word 20
  task automatic run_dump(input int mode);
    int          eq_i[$];
    logic [31:0] eq_d[$];
    int          n, acc, last_n, dones, stall;
    bit          stop;
    logic        pv, pr;
    logic [4:0]  pi;
    logic [31:0] pd;
    for (int i = 0; i < 32; i++) begin
      eq_i.push_back(i);
      eq_d.push_back(m_rf[i]);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 1; acc = 0; last_n = -10; dones = 0; stall = 0;
    stop = 0; pv = 0; pr = 0; pi = '0; pd = '0;
    while (n < 400 && !stop) begin
      if (pv && !pr) begin
        chk("hold_v", out_valid, 1);
        chk("hold_i", out_idx, pi);
        chk("hold_d", out_data, pd);
      end
      if (done) begin
        dones++;
        chk("done_after_last", eq_i.size(), 0);
        chk("done_gap", n - last_n, 1);
        if (mode == 0) chk("done_edge", n - 1, 64);
        break;
      end
      out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && out_valid && out_idx == 5'd3 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end
      if (mode == 3 && out_valid && out_idx == 5'd10) begin
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_ov", out_valid, 0);
        chk("abort_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
          if (done) dones++;
          cyc();
        end
        chk("abort_nodone", dones, 0);
        chk("abort_idle", busy, 0);
        stop = 1;
      end else if (mode == 5 && out_valid && out_idx == 5'd20) begin
        #2 clrn = 1'b0;
        #1 chk_zero("rst_mid");
        cyc();
        clrn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          cyc();
          chk("rst_stay_idle", busy, 0);
        end
        chk("rst_ov", out_valid, 0);
        stop = 1;
      end else begin
        if (mode == 4 && out_valid && out_idx == 5'd7) start = 1'b1;
        if (out_valid && out_ready) begin
          if (eq_i.size() == 0) begin
            chk("extra_word", out_idx, 32);
          end else begin
            chk("word_idx", out_idx, eq_i.pop_front());
            chk("word_data", out_data, eq_d.pop_front());
          end
          acc++;
          last_n = n;
        end
        pv = out_valid; pr = out_ready; pi = out_idx; pd = out_data;
        cyc();
        start = 1'b0;
        n++;
      end
    end
    out_ready = 1'b0;
    if (!stop) begin
      chk("no_timeout", n < 400, 1);
      chk("word_count", acc, 32);
      chk("done_count", dones, 1);
      if (mode == 2) chk("stall_len", stall, 5);
      cyc();
      chk("end_idle", busy, 0);
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    clrn = 1'b1;
    #3 clrn = 1'b0;
    #2 chk_zero("reset");
    cyc();
    cyc();
    clrn = 1'b1;
    cyc();
    chk("idle_no_start", busy, 0);

    m_rf[0] = 32'h0;
    for (int k = 0; k < 32; k++) wr(k, 32'(k) * 32'h01010101);
    run_dump(0);

    wr(3, 32'hDEADBEEF);
    run_dump(2);

    run_dump(3);
    run_dump(0);

    run_dump(4);

    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 8; k++) wr($urandom_range(0, 31), $urandom);
      run_dump(1);
    end

    wr(29, 32'h12345678);
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    chk("one_load_ov", ov2, 0);
    chk("one_busy", busy2, 1);
    cyc();
    chk("one_ov", ov2, 1);
    chk("one_idx", oi2, 29);
    chk("one_data", od2, 32'h12345678);
    ready2 = 1'b1;
    cyc();
    ready2 = 1'b0;
    chk("one_done", done2, 1);
    chk("one_ov_clr", ov2, 0);
    cyc();
    chk("one_done_off", done2, 0);
    chk("one_idle", busy2, 0);

    run_dump(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
